// File: rtl/soc_single.sv
// soc_single -- minimal single-core SoC top.
//
// A single-cycle RV32I-subset core is wired to a private byte-wide
// instruction memory (1024 x 8) and a word-wide data memory (256 x 32).
// The core starts at address 0 after reset and retires one instruction per
// rising clock edge while fetch_enable_i is high. Software reports
// completion by writing a result to data word 1 and a nonzero flag to
// data word 0.
//
// Ports:
//   clk_i           in   1  system clock, rising edge
//   rst_i           in   1  asynchronous active-high reset
//   fetch_enable_i  in   1  1: execute, 0: stall (PC, registers, memories hold)
//   instr_addr_o    out 32  current PC (byte address)
//   data_addr_o     out 32  byte address of the current load/store
//   data_we_o       out  1  store in progress this cycle
//   data_be_o       out  4  byte enables of the current load/store
//   data_wdata_o    out 32  store data, replicated to every lane

// ---------------------------------------------------------------------------
// Instruction memory: 1024 bytes, little-endian 32-bit combinational fetch.
// The write port is a program-loading hook; in this SoC it is tied off and
// the contents are preloaded hierarchically.
// ---------------------------------------------------------------------------
module soc_inst_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic [9:0]  addr,
  output logic [31:0] instr
);
  logic [7:0] mem [0:1023];
  logic [9:0] addr_1, addr_2, addr_3;

  // 10-bit adds so a fetch near the top of memory wraps back to byte 0
  assign addr_1 = addr + 10'd1;
  assign addr_2 = addr + 10'd2;
  assign addr_3 = addr + 10'd3;

  assign instr = {mem[addr_3], mem[addr_2], mem[addr_1], mem[addr]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
endmodule

// ---------------------------------------------------------------------------
// Data memory: 256 words, combinational read, byte-lane masked write.
// ---------------------------------------------------------------------------
module soc_data_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [7:0]  word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:255];

  assign rdata = mem[word_addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[word_addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end
endmodule

// ---------------------------------------------------------------------------
// Top: single-cycle core plus the two memories.
// ---------------------------------------------------------------------------
module soc_single (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  output logic [31:0] instr_addr_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  logic [31:0] pc_reg, pc_next, pc_plus4;
  logic [31:0] rf_reg [0:31];
  logic [31:0] instr;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] ls_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        br_taken;

  logic        rd_we;
  logic [31:0] rd_wdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic [31:0] mem_wdata;

  // -------------------------------------------------------------------------
  // Memories
  // -------------------------------------------------------------------------
  soc_inst_mem inst_mem (
    .clk   (clk_i),
    .we    (1'b0),
    .waddr (10'd0),
    .wdata (8'd0),
    .addr  (pc_reg[9:0]),
    .instr (instr)
  );

  soc_data_mem data_mem (
    .clk       (clk_i),
    .we        (data_we_o),
    .be        (mem_be),
    .word_addr (mem_addr[9:2]),
    .wdata     (mem_wdata),
    .rdata     (mem_rdata)
  );

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is forced to zero on read; it is also never written
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_reg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_reg[rs2];

  assign pc_plus4 = pc_reg + 32'd4;
  assign ls_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

  // Lane extraction for sub-word loads: bytes by addr[1:0], halves by addr[1]
  always_comb begin
    load_byte = mem_rdata[7:0];
    case (ls_addr[1:0])
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
  end

  assign load_half = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Shared ALU for register-register and register-immediate forms.
  // alt selects SUB (register form only) or SRA/SRAI.
  function automatic logic [31:0] alu_op(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [2:0]  op,
                                         input logic        alt);
    logic [4:0] sh;
    sh = b[4:0];
    alu_op = 32'd0;
    case (op)
      3'b000: begin
        if (alt) alu_op = a - b;
        else     alu_op = a + b;
      end
      3'b001: alu_op = a << sh;
      3'b010: alu_op = {31'd0, ($signed(a) < $signed(b))};
      3'b011: alu_op = {31'd0, (a < b)};
      3'b100: alu_op = a ^ b;
      3'b101: begin
        if (alt) alu_op = $signed(a) >>> sh;
        else     alu_op = a >> sh;
      end
      3'b110: alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Execute: next PC, register write-back and memory request
  // -------------------------------------------------------------------------
  always_comb begin
    pc_next   = pc_plus4;
    rd_we     = 1'b0;
    rd_wdata  = 32'd0;
    mem_addr  = 32'd0;
    mem_be    = 4'b0000;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;

    case (opcode)
      OPC_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OPC_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc_reg + imm_u;
      end
      OPC_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = pc_reg + imm_j;
      end
      OPC_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        if (br_taken) pc_next = pc_reg + imm_b;
      end
      OPC_LOAD: begin
        // Unknown widths fall through as a NOP: no enables, no write-back
        case (funct3)
          3'b000: begin
            rd_we    = 1'b1;
            rd_wdata = {{24{load_byte[7]}}, load_byte};
            mem_addr = ls_addr;
            mem_be   = 4'b0001 << ls_addr[1:0];
          end
          3'b100: begin
            rd_we    = 1'b1;
            rd_wdata = {24'd0, load_byte};
            mem_addr = ls_addr;
            mem_be   = 4'b0001 << ls_addr[1:0];
          end
          3'b001: begin
            rd_we    = 1'b1;
            rd_wdata = {{16{load_half[15]}}, load_half};
            mem_addr = ls_addr;
            mem_be   = ls_addr[1] ? 4'b1100 : 4'b0011;
          end
          3'b101: begin
            rd_we    = 1'b1;
            rd_wdata = {16'd0, load_half};
            mem_addr = ls_addr;
            mem_be   = ls_addr[1] ? 4'b1100 : 4'b0011;
          end
          3'b010: begin
            rd_we    = 1'b1;
            rd_wdata = mem_rdata;
            mem_addr = ls_addr;
            mem_be   = 4'b1111;
          end
          default: ;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000: begin
            mem_we    = 1'b1;
            mem_addr  = ls_addr;
            mem_be    = 4'b0001 << ls_addr[1:0];
            mem_wdata = {4{rs2_val[7:0]}};
          end
          3'b001: begin
            mem_we    = 1'b1;
            mem_addr  = ls_addr;
            mem_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{rs2_val[15:0]}};
          end
          3'b010: begin
            mem_we    = 1'b1;
            mem_addr  = ls_addr;
            mem_be    = 4'b1111;
            mem_wdata = rs2_val;
          end
          default: ;
        endcase
      end
      OPC_IMM: begin
        rd_we    = 1'b1;
        // funct7 only carries meaning for the right shifts here; for the
        // other immediates those bits belong to the immediate itself
        rd_wdata = alu_op(rs1_val, imm_i, funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_REG: begin
        rd_we    = 1'b1;
        rd_wdata = alu_op(rs1_val, rs2_val, funct3, funct7[5]);
      end
      default: ;  // FENCE, SYSTEM and anything unknown retire as NOP
    endcase
  end

  // -------------------------------------------------------------------------
  // Architectural state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_reg <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_reg[i] <= 32'd0;
      end
    end else if (fetch_enable_i) begin
      pc_reg <= pc_next;
      if (rd_we && (rd != 5'd0)) begin
        rf_reg[rd] <= rd_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The bus is masked straight from rst_i so that a store that is
  // in flight when reset arrives is dropped without waiting for a clock.
  // -------------------------------------------------------------------------
  assign instr_addr_o = pc_reg;
  assign data_addr_o  = rst_i ? 32'd0 : mem_addr;
  assign data_we_o    = mem_we & fetch_enable_i & ~rst_i;
  assign data_be_o    = rst_i ? 4'b0000 : mem_be;
  assign data_wdata_o = rst_i ? 32'd0 : mem_wdata;

endmodule

// File: tb/tb_soc_single.sv
// tb_soc_single -- directed self-checking bench for soc_single.
// Small programs are assembled by helper functions, preloaded through the
// hierarchical memory arrays, run, and checked against hand-computed values.
module tb_soc_single;
  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] instr_addr;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;

  int check_cnt = 0;
  int err_cnt   = 0;

  soc_single dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fetch_en),
    .instr_addr_o   (instr_addr),
    .data_addr_o    (data_addr),
    .data_we_o      (data_we),
    .data_be_o      (data_be),
    .data_wdata_o   (data_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_s(imm, rs2, rs1, 3'd2);
  endfunction

  // ---------------- program / memory helpers ----------------
  task automatic put(input int idx, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      dut.inst_mem.mem[idx*4 + b] = w[b*8 +: 8];
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 1024; i++) dut.inst_mem.mem[i] = 8'h00;
    for (int i = 0; i < 256; i++)  dut.data_mem.mem[i] = 32'h0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with rst=1: one more clock in reset, then release
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int fib_cycles;
  logic fib_done;

  initial begin
    rst      = 1'b1;
    fetch_en = 1'b1;

    // ================= Program A: reset, store, stall =================
    clear_mems();
    put(0, sw(5'd0, 5'd0, 32'd8));        // 0: sw   x0,8(x0)
    put(1, addi(5'd1, 5'd0, 32'd55));     // 4: addi x1,x0,55
    put(2, sw(5'd1, 5'd0, 32'd4));        // 8: sw   x1,4(x0)
    dut.data_mem.mem[1] = 32'hDEADBEEF;
    dut.data_mem.mem[2] = 32'h12345678;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr_addr", instr_addr, 32'd0);
    check("rst_data_we",    32'(data_we), 32'd0);
    check("rst_data_be",    32'(data_be), 32'd0);
    check("rst_data_addr",  data_addr, 32'd0);
    check("rst_data_wdata", data_wdata, 32'd0);
    check("rst_no_write",   dut.data_mem.mem[2], 32'h12345678);

    rst = 1'b0;
    #1;
    check("a_pc0",        instr_addr, 32'd0);
    check("a_sw0_we",     32'(data_we), 32'd1);
    check("a_sw0_addr",   data_addr, 32'd8);
    step(1);
    check("a_pc4",        instr_addr, 32'd4);
    check("a_sw0_mem",    dut.data_mem.mem[2], 32'd0);
    check("a_addi_be",    32'(data_be), 32'd0);
    step(1);
    check("a_pc8",        instr_addr, 32'd8);
    check("a_sw_we",      32'(data_we), 32'd1);
    check("a_sw_addr",    data_addr, 32'd4);
    check("a_sw_be",      32'(data_be), 32'hF);
    check("a_sw_wdata",   data_wdata, 32'd55);

    // Stall on the store: write enable drops, everything else holds
    fetch_en = 1'b0;
    #1;
    check("stall_we",     32'(data_we), 32'd0);
    check("stall_be",     32'(data_be), 32'hF);
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("stall_pc",   instr_addr, 32'd8);
    end
    check("stall_mem",    dut.data_mem.mem[1], 32'hDEADBEEF);
    fetch_en = 1'b1;
    #1;
    check("resume_we",    32'(data_we), 32'd1);
    step(1);
    check("resume_pc",    instr_addr, 32'd12);
    check("a_sw_mem",     dut.data_mem.mem[1], 32'd55);
    check("a_nop_we",     32'(data_we), 32'd0);

    // ================= Mid-program reset aborts a pending store =================
    rst = 1'b1;
    dut.data_mem.mem[1] = 32'hDEADBEEF;
    release_reset();
    step(2);
    check("mid_pc8",      instr_addr, 32'd8);
    rst = 1'b1;
    #1;
    check("mid_rst_pc",   instr_addr, 32'd0);
    check("mid_rst_we",   32'(data_we), 32'd0);
    check("mid_rst_be",   32'(data_be), 32'd0);
    step(1);
    check("mid_rst_mem",  dut.data_mem.mem[1], 32'hDEADBEEF);

    // ================= Program C: byte/half stores and loads =================
    clear_mems();
    put(0,  addi(5'd1, 5'd0, 32'hAB));                  // 0:  addi x1,x0,0xAB
    put(1,  enc_s(32'd3, 5'd1, 5'd0, 3'd0));            // 4:  sb   x1,3(x0)
    put(2,  enc_i(32'd3, 5'd0, 3'd4, 5'd2, 7'h03));     // 8:  lbu  x2,3(x0)
    put(3,  enc_i(32'd3, 5'd0, 3'd0, 5'd3, 7'h03));     // 12: lb   x3,3(x0)
    put(4,  sw(5'd2, 5'd0, 32'd8));                     // 16: sw   x2,8(x0)
    put(5,  sw(5'd3, 5'd0, 32'd12));                    // 20: sw   x3,12(x0)
    put(6,  addi(5'd0, 5'd1, 32'd5));                   // 24: addi x0,x1,5
    put(7,  sw(5'd0, 5'd0, 32'd16));                    // 28: sw   x0,16(x0)
    put(8,  enc_s(32'd6, 5'd3, 5'd0, 3'd1));            // 32: sh   x3,6(x0)
    put(9,  enc_i(32'd6, 5'd0, 3'd5, 5'd4, 7'h03));     // 36: lhu  x4,6(x0)
    put(10, sw(5'd4, 5'd0, 32'd20));                    // 40: sw   x4,20(x0)
    put(11, enc_j(32'd0, 5'd0));                        // 44: jal  x0,0
    dut.data_mem.mem[0] = 32'h11223344;
    dut.data_mem.mem[4] = 32'hCAFEF00D;
    release_reset();
    step(1);
    check("c_sb_be",      32'(data_be), 32'h8);
    check("c_sb_addr",    data_addr, 32'd3);
    check("c_sb_wdata",   data_wdata, 32'hABABABAB);
    check("c_sb_we",      32'(data_we), 32'd1);
    step(1);
    check("c_lbu_be",     32'(data_be), 32'h8);
    check("c_lbu_we",     32'(data_we), 32'd0);
    step(6);
    check("c_sh_pc",      instr_addr, 32'd32);
    check("c_sh_be",      32'(data_be), 32'hC);
    check("c_sh_wdata",   data_wdata, 32'hFFABFFAB);
    step(6);
    check("c_sb_mem",     dut.data_mem.mem[0], 32'hAB223344);
    check("c_lbu_x2",     dut.data_mem.mem[2], 32'h000000AB);
    check("c_lb_x3",      dut.data_mem.mem[3], 32'hFFFFFFAB);
    check("c_x0_zero",    dut.data_mem.mem[4], 32'd0);
    check("c_sh_mem",     dut.data_mem.mem[1], 32'hFFAB0000);
    check("c_lhu_x4",     dut.data_mem.mem[5], 32'h0000FFAB);

    // ================= Program D: BNE loop, JAL/JALR =================
    rst = 1'b1;
    clear_mems();
    put(0,  addi(5'd1, 5'd0, 32'd10));                  // 0:  addi x1,x0,10
    put(1,  addi(5'd2, 5'd0, 32'd0));                   // 4:  addi x2,x0,0
    put(2,  addi(5'd2, 5'd2, 32'd3));                   // 8:  addi x2,x2,3
    put(3,  addi(5'd1, 5'd1, -32'd1));                  // 12: addi x1,x1,-1
    put(4,  enc_b(-32'd8, 5'd0, 5'd1, 3'd1));           // 16: bne  x1,x0,-8
    put(5,  enc_j(32'd16, 5'd5));                       // 20: jal  x5,+16
    put(6,  sw(5'd2, 5'd0, 32'd4));                     // 24: sw   x2,4(x0)
    put(7,  sw(5'd6, 5'd0, 32'd12));                    // 28: sw   x6,12(x0)
    put(8,  enc_j(32'd0, 5'd0));                        // 32: jal  x0,0
    put(9,  sw(5'd5, 5'd0, 32'd8));                     // 36: sw   x5,8(x0)
    put(10, enc_i(32'd1, 5'd5, 3'd0, 5'd6, 7'h67));     // 40: jalr x6,1(x5)
    release_reset();
    step(5);
    check("d_pc_e5",      instr_addr, 32'd8);
    step(27);
    check("d_pc_e32",     instr_addr, 32'd20);
    step(1);
    check("d_pc_e33",     instr_addr, 32'd36);
    step(1);
    check("d_jalr_be",    32'(data_be), 32'd0);
    step(1);
    check("d_pc_e35",     instr_addr, 32'd24);
    step(5);
    check("d_pc_e40",     instr_addr, 32'd32);
    check("d_loop_sum",   dut.data_mem.mem[1], 32'd30);
    check("d_jal_link",   dut.data_mem.mem[2], 32'd24);
    check("d_jalr_link",  dut.data_mem.mem[3], 32'd44);

    // ================= Program F: ALU / compare / branch mix =================
    rst = 1'b1;
    clear_mems();
    put(0,  enc_u(20'h80000, 5'd1, 7'h37));             // 0:  lui  x1,0x80000
    put(1,  addi(5'd2, 5'd0, -32'd3));                  // 4:  addi x2,x0,-3
    put(2,  enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3));      // 8:  sra  x3,x1,x2
    put(3,  sw(5'd3, 5'd0, 32'd0));                     // 12: sw   x3,0(x0)
    put(4,  enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3));      // 16: srl  x3,x1,x2
    put(5,  sw(5'd3, 5'd0, 32'd4));                     // 20: sw   x3,4(x0)
    put(6,  enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd3));      // 24: sub  x3,x0,x2
    put(7,  enc_r(7'h00, 5'd2, 5'd3, 3'd3, 5'd4));      // 28: sltu x4,x3,x2
    put(8,  enc_r(7'h00, 5'd3, 5'd2, 3'd2, 5'd5));      // 32: slt  x5,x2,x3
    put(9,  enc_i(32'd4, 5'd4, 3'd1, 5'd4, 7'h13));     // 36: slli x4,x4,4
    put(10, enc_r(7'h00, 5'd5, 5'd4, 3'd6, 5'd4));      // 40: or   x4,x4,x5
    put(11, enc_i(32'hFF, 5'd4, 3'd4, 5'd4, 7'h13));    // 44: xori x4,x4,0xFF
    put(12, sw(5'd4, 5'd0, 32'd8));                     // 48: sw   x4,8(x0)
    put(13, enc_u(20'h00001, 5'd6, 7'h17));             // 52: auipc x6,1
    put(14, sw(5'd6, 5'd0, 32'd12));                    // 56: sw   x6,12(x0)
    put(15, enc_b(32'd8, 5'd3, 5'd2, 3'd4));            // 60: blt  x2,x3,+8
    put(16, sw(5'd1, 5'd0, 32'd16));                    // 64: (skipped)
    put(17, enc_b(32'd8, 5'd3, 5'd2, 3'd7));            // 68: bgeu x2,x3,+8
    put(18, sw(5'd1, 5'd0, 32'd16));                    // 72: (skipped)
    put(19, enc_b(32'd8, 5'd3, 5'd2, 3'd6));            // 76: bltu x2,x3,+8 (not taken)
    put(20, enc_i(32'd2, 5'd0, 3'd5, 5'd7, 7'h03));     // 80: lhu  x7,2(x0)
    put(21, enc_i(32'h7F0, 5'd7, 3'd7, 5'd7, 7'h13));   // 84: andi x7,x7,0x7F0
    put(22, sw(5'd7, 5'd0, 32'd20));                    // 88: sw   x7,20(x0)
    put(23, enc_j(32'd0, 5'd0));                        // 92: jal  x0,0
    dut.data_mem.mem[4] = 32'h5A5A5A5A;
    release_reset();
    step(30);
    check("f_sra",        dut.data_mem.mem[0], 32'hFFFFFFFC);
    check("f_srl",        dut.data_mem.mem[1], 32'h00000004);
    check("f_cmp_logic",  dut.data_mem.mem[2], 32'h000000EE);
    check("f_auipc",      dut.data_mem.mem[3], 32'h00001034);
    check("f_br_skip",    dut.data_mem.mem[4], 32'h5A5A5A5A);
    check("f_lhu_andi",   dut.data_mem.mem[5], 32'h000007F0);
    check("f_halt_pc",    instr_addr, 32'd92);

    // ================= Program E: Fibonacci =================
    rst = 1'b1;
    clear_mems();
    put(0,  addi(5'd1, 5'd0, 32'd0));                   // 0:  addi x1,x0,0
    put(1,  addi(5'd2, 5'd0, 32'd1));                   // 4:  addi x2,x0,1
    put(2,  addi(5'd3, 5'd0, 32'd10));                  // 8:  addi x3,x0,10
    put(3,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4));      // 12: add  x4,x1,x2
    put(4,  addi(5'd1, 5'd2, 32'd0));                   // 16: addi x1,x2,0
    put(5,  addi(5'd2, 5'd4, 32'd0));                   // 20: addi x2,x4,0
    put(6,  addi(5'd3, 5'd3, -32'd1));                  // 24: addi x3,x3,-1
    put(7,  enc_b(-32'd16, 5'd0, 5'd3, 3'd1));          // 28: bne  x3,x0,-16
    put(8,  sw(5'd1, 5'd0, 32'd4));                     // 32: sw   x1,4(x0)
    put(9,  addi(5'd5, 5'd0, 32'd1));                   // 36: addi x5,x0,1
    put(10, sw(5'd5, 5'd0, 32'd0));                     // 40: sw   x5,0(x0)
    put(11, enc_j(32'd0, 5'd0));                        // 44: jal  x0,0
    release_reset();
    fib_cycles = 0;
    fib_done   = 1'b0;
    // 100 cycles of a 10-time-unit clock is the 1000 ns budget
    while (!fib_done && fib_cycles < 100) begin
      step(1);
      fib_cycles++;
      if (dut.data_mem.mem[0] != 32'd0) fib_done = 1'b1;
    end
    check("fib_in_budget", 32'(fib_done), 32'd1);
    check("fib_flag",      dut.data_mem.mem[0], 32'd1);
    check("fib_result",    dut.data_mem.mem[1], 32'd55);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end
endmodule
